// File: rtl/axi_slice_pkg.sv
// Shared types and payload-width helpers for the AXI4 register slice.
// Each width helper returns the packed width of one channel's payload.
package axi_slice_pkg;

   typedef enum logic [1:0] {
      SLICE_BYPASS = 2'd0,
      SLICE_FULL   = 2'd1,
      SLICE_LIGHT  = 2'd2
   } slice_mode_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } fill_state_e;

   localparam int unsigned AXI_LEN_W    = 8;
   localparam int unsigned AXI_SIZE_W   = 3;
   localparam int unsigned AXI_BURST_W  = 2;
   localparam int unsigned AXI_CACHE_W  = 4;
   localparam int unsigned AXI_PROT_W   = 3;
   localparam int unsigned AXI_QOS_W    = 4;
   localparam int unsigned AXI_REGION_W = 4;
   localparam int unsigned AXI_RESP_W   = 2;

   // AW and AR share one layout; the extra 1 is the lock bit.
   function automatic int unsigned aw_width(int unsigned id_w, int unsigned addr_w,
                                            int unsigned user_w);
      return id_w + addr_w + AXI_LEN_W + AXI_SIZE_W + AXI_BURST_W + 1 + AXI_CACHE_W
             + AXI_PROT_W + AXI_QOS_W + AXI_REGION_W + user_w;
   endfunction

   function automatic int unsigned ar_width(int unsigned id_w, int unsigned addr_w,
                                            int unsigned user_w);
      return aw_width(id_w, addr_w, user_w);
   endfunction

   function automatic int unsigned w_width(int unsigned data_w, int unsigned user_w);
      return data_w + data_w / 8 + 1 + user_w;
   endfunction

   function automatic int unsigned b_width(int unsigned id_w, int unsigned user_w);
      return id_w + AXI_RESP_W + user_w;
   endfunction

   function automatic int unsigned r_width(int unsigned id_w, int unsigned data_w,
                                           int unsigned user_w);
      return id_w + data_w + AXI_RESP_W + 1 + user_w;
   endfunction

endpackage

// File: rtl/axi_interface.sv
// AXI4 bundle with master/slave views; the field widths agree with the axi_slice_pkg helpers.
interface axi_interface #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ID_WIDTH   = 4,
   parameter int unsigned AXI_USER_WIDTH = 1
);
   logic [AXI_ID_WIDTH-1:0]     awid,   arid,   bid,   rid;
   logic [AXI_ADDR_WIDTH-1:0]   awaddr, araddr;
   logic [7:0]                  awlen,  arlen;
   logic [2:0]                  awsize, arsize;
   logic [1:0]                  awburst, arburst;
   logic                        awlock, arlock;
   logic [3:0]                  awcache, arcache;
   logic [2:0]                  awprot, arprot;
   logic [3:0]                  awqos,  arqos;
   logic [3:0]                  awregion, arregion;
   logic [AXI_USER_WIDTH-1:0]   awuser, aruser, wuser, buser, ruser;
   logic                        awvalid, awready, arvalid, arready;
   logic [AXI_DATA_WIDTH-1:0]   wdata,  rdata;
   logic [AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                        wlast,  rlast;
   logic                        wvalid, wready, rvalid, rready;
   logic [1:0]                  bresp,  rresp;
   logic                        bvalid, bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
             awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
             arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
             aruser, arvalid, rready,
      input  awready, wready, bid, bresp, buser, bvalid, arready,
             rid, rdata, rresp, rlast, ruser, rvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
             awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
             arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
             aruser, arvalid, rready,
      output awready, wready, bid, bresp, buser, bvalid, arready,
             rid, rdata, rresp, rlast, ruser, rvalid
   );
endinterface

// File: rtl/axi_reg_stage.sv
// Generic valid/ready pipeline stage: wire-through, 2-entry skid buffer, or half-rate single register.
// Handshake outputs are flop-driven in the buffered modes; payload registers carry no reset.
module axi_reg_stage
   import axi_slice_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter slice_mode_e MODE  = SLICE_FULL
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             empty
);

   if (MODE == SLICE_BYPASS) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk, rst_n};
      assign out_valid     = in_valid;
      assign in_ready      = out_ready;
      assign out_data      = in_data;
      assign empty         = 1'b1;

   end else if (MODE == SLICE_FULL) begin : g_full
      fill_state_e      state;
      logic             in_rdy_q, out_vld_q, in_hs, out_hs;
      logic [WIDTH-1:0] main_p0, skid_p0;

      assign in_hs     = in_valid && in_rdy_q;
      assign out_hs    = out_vld_q && out_ready;
      assign in_ready  = in_rdy_q;
      assign out_valid = out_vld_q;
      assign out_data  = main_p0;
      assign empty     = !out_vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state     <= ST_EMPTY;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
         end else begin
            case (state)
               ST_EMPTY: if (in_hs) begin
                  state     <= ST_ONE;
                  out_vld_q <= 1'b1;
               end
               ST_ONE: if (in_hs && !out_hs) begin
                  state    <= ST_TWO;
                  in_rdy_q <= 1'b0;
               end else if (!in_hs && out_hs) begin
                  state     <= ST_EMPTY;
                  out_vld_q <= 1'b0;
               end
               ST_TWO: if (out_hs) begin
                  state    <= ST_ONE;
                  in_rdy_q <= 1'b1;
               end
               default: begin
                  state     <= ST_EMPTY;
                  in_rdy_q  <= 1'b1;
                  out_vld_q <= 1'b0;
               end
            endcase
         end
      end

      // Main feeds the output; skid catches the beat accepted while the output stalls.
      always_ff @(posedge clk) begin
         case (state)
            ST_EMPTY: if (in_hs) main_p0 <= in_data;
            ST_ONE: begin
               if (in_hs && out_hs) main_p0 <= in_data;
               else if (in_hs)      skid_p0 <= in_data;
            end
            ST_TWO: if (out_hs) main_p0 <= skid_p0;
            default: begin end
         endcase
      end

   end else if (MODE == SLICE_LIGHT) begin : g_light
      logic             full_q, rdy_q;
      logic [WIDTH-1:0] main_p0;

      assign in_ready  = rdy_q;
      assign out_valid = full_q;
      assign out_data  = main_p0;
      assign empty     = !full_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            full_q <= 1'b0;
            rdy_q  <= 1'b1;
         end else if (!full_q && in_valid) begin
            full_q <= 1'b1;
            rdy_q  <= 1'b0;
         end else if (full_q && out_ready) begin
            full_q <= 1'b0;
            rdy_q  <= 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (in_valid && rdy_q) main_p0 <= in_data;
      end

   end else begin : g_bad_mode
      $fatal(1, "axi_reg_stage: unsupported MODE");
   end

endmodule

// File: rtl/axi_reg_slice.sv
// AXI4 register slice: one independently configured stage per channel between s_axi and m_axi.
// idle is the AND of every stage's empty flag, so it is a pure function of flop outputs.
module axi_reg_slice
   import axi_slice_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ID_WIDTH   = 4,
   parameter int unsigned AXI_USER_WIDTH = 1,
   parameter slice_mode_e AW_MODE        = SLICE_FULL,
   parameter slice_mode_e W_MODE         = SLICE_FULL,
   parameter slice_mode_e B_MODE         = SLICE_FULL,
   parameter slice_mode_e AR_MODE        = SLICE_FULL,
   parameter slice_mode_e R_MODE         = SLICE_FULL
) (
   input  logic         clk,
   input  logic         rst_n,
   axi_interface.slave  s_axi,
   axi_interface.master m_axi,
   output logic         idle
);

   localparam int unsigned AW_W = aw_width(AXI_ID_WIDTH, AXI_ADDR_WIDTH, AXI_USER_WIDTH);
   localparam int unsigned W_W  = w_width(AXI_DATA_WIDTH, AXI_USER_WIDTH);
   localparam int unsigned B_W  = b_width(AXI_ID_WIDTH, AXI_USER_WIDTH);
   localparam int unsigned AR_W = ar_width(AXI_ID_WIDTH, AXI_ADDR_WIDTH, AXI_USER_WIDTH);
   localparam int unsigned R_W  = r_width(AXI_ID_WIDTH, AXI_DATA_WIDTH, AXI_USER_WIDTH);

   if (AXI_DATA_WIDTH % 8 != 0) begin : g_bad_width
      $fatal(1, "axi_reg_slice: AXI_DATA_WIDTH must be a multiple of 8");
   end

   logic [AW_W-1:0] aw_in, aw_out;
   logic [W_W-1:0]  w_in,  w_out;
   logic [B_W-1:0]  b_in,  b_out;
   logic [AR_W-1:0] ar_in, ar_out;
   logic [R_W-1:0]  r_in,  r_out;
   logic            aw_empty, w_empty, b_empty, ar_empty, r_empty;

   assign aw_in = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst,
                   s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.awregion,
                   s_axi.awuser};
   assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst,
           m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awqos, m_axi.awregion,
           m_axi.awuser} = aw_out;

   assign w_in = {s_axi.wdata, s_axi.wstrb, s_axi.wlast, s_axi.wuser};
   assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast, m_axi.wuser} = w_out;

   assign b_in = {m_axi.bid, m_axi.bresp, m_axi.buser};
   assign {s_axi.bid, s_axi.bresp, s_axi.buser} = b_out;

   assign ar_in = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst,
                   s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.arregion,
                   s_axi.aruser};
   assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst,
           m_axi.arlock, m_axi.arcache, m_axi.arprot, m_axi.arqos, m_axi.arregion,
           m_axi.aruser} = ar_out;

   assign r_in = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast, m_axi.ruser};
   assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.ruser} = r_out;

   // Forward channels run s_axi -> m_axi, response channels m_axi -> s_axi.
   axi_reg_stage #(.WIDTH(AW_W), .MODE(AW_MODE)) u_aw_stage (
      .clk, .rst_n,
      .in_valid(s_axi.awvalid), .in_ready(s_axi.awready), .in_data(aw_in),
      .out_valid(m_axi.awvalid), .out_ready(m_axi.awready), .out_data(aw_out),
      .empty(aw_empty)
   );

   axi_reg_stage #(.WIDTH(W_W), .MODE(W_MODE)) u_w_stage (
      .clk, .rst_n,
      .in_valid(s_axi.wvalid), .in_ready(s_axi.wready), .in_data(w_in),
      .out_valid(m_axi.wvalid), .out_ready(m_axi.wready), .out_data(w_out),
      .empty(w_empty)
   );

   axi_reg_stage #(.WIDTH(B_W), .MODE(B_MODE)) u_b_stage (
      .clk, .rst_n,
      .in_valid(m_axi.bvalid), .in_ready(m_axi.bready), .in_data(b_in),
      .out_valid(s_axi.bvalid), .out_ready(s_axi.bready), .out_data(b_out),
      .empty(b_empty)
   );

   axi_reg_stage #(.WIDTH(AR_W), .MODE(AR_MODE)) u_ar_stage (
      .clk, .rst_n,
      .in_valid(s_axi.arvalid), .in_ready(s_axi.arready), .in_data(ar_in),
      .out_valid(m_axi.arvalid), .out_ready(m_axi.arready), .out_data(ar_out),
      .empty(ar_empty)
   );

   axi_reg_stage #(.WIDTH(R_W), .MODE(R_MODE)) u_r_stage (
      .clk, .rst_n,
      .in_valid(m_axi.rvalid), .in_ready(m_axi.rready), .in_data(r_in),
      .out_valid(s_axi.rvalid), .out_ready(s_axi.rready), .out_data(r_out),
      .empty(r_empty)
   );

   assign idle = aw_empty & w_empty & b_empty & ar_empty & r_empty;

endmodule
